// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX-resolved branches, dmem wait/timeout.
// Optional saturating performance counters are added when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic [4:0]       rt_ex,
    input  logic             memread_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             mem_err,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
`endif
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ACT_ADVANCE   = 3'd0,
        ACT_FREEZE    = 3'd1,
        ACT_BRANCH    = 3'd2,
        ACT_LOAD_USE  = 3'd3,
        ACT_FLUSH_BUB = 3'd4
    } act_t;

    // The timer holds the count of completed MEM_WAIT cycles; the one that reaches MEM_TIMEOUT-1 expires.
    localparam logic [9:0] TIMER_LAST      = 10'(MEM_TIMEOUT - 2);
    localparam logic [2:0] FLUSH_INIT      = 3'(FLUSH_CYCLES - 1);
    localparam bit         BRANCH_TO_FLUSH = (FLUSH_CYCLES > 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || MEM_TIMEOUT < 2 || MEM_TIMEOUT > 1023 || CNT_W < 1) begin : g_param_check
        $error("pipe_hazard_ctrl: parameter out of range");
    end

    state_t     state_r, state_s;
    logic [9:0] timer_r, timer_s;
    logic       pend_flush_r, pend_flush_s;
    logic [2:0] flush_cnt_r, flush_cnt_s;
    act_t       act_s;
    logic       load_use_s;
    logic       mem_stall_s;

    assign load_use_s  = memread_ex && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
    assign mem_stall_s = dmem_req && !dmem_ack;
    assign state_o     = state_r;

    // Action selection and next-state computation
    always_comb begin
        act_s        = ACT_ADVANCE;
        state_s      = state_r;
        timer_s      = timer_r;
        pend_flush_s = pend_flush_r;
        flush_cnt_s  = flush_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_stall_s) begin
                    act_s        = ACT_FREEZE;
                    pend_flush_s = pend_flush_r | branch_taken_ex;
                    timer_s      = 10'd0;
                    state_s      = ST_MEM_WAIT;
                end else if (branch_taken_ex) begin
                    act_s       = ACT_BRANCH;
                    flush_cnt_s = FLUSH_INIT;
                    state_s     = BRANCH_TO_FLUSH ? ST_FLUSH : ST_IDLE;
                end else if (load_use_s) begin
                    act_s = ACT_LOAD_USE;
                end else begin
                    act_s = ACT_ADVANCE;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ack) begin
                    act_s        = ACT_FREEZE;
                    timer_s      = timer_r + 10'd1;
                    pend_flush_s = pend_flush_r | branch_taken_ex;
                    state_s      = (timer_r == TIMER_LAST) ? ST_ERR : ST_MEM_WAIT;
                end else if (pend_flush_r) begin
                    // Branch seen while frozen is replayed on the ack cycle
                    act_s        = ACT_BRANCH;
                    pend_flush_s = 1'b0;
                    flush_cnt_s  = FLUSH_INIT;
                    state_s      = BRANCH_TO_FLUSH ? ST_FLUSH : ST_IDLE;
                end else begin
                    act_s   = ACT_ADVANCE;
                    state_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (mem_stall_s) begin
                    act_s        = ACT_FREEZE;
                    pend_flush_s = 1'b0;
                    timer_s      = 10'd0;
                    state_s      = ST_MEM_WAIT;
                end else if (branch_taken_ex) begin
                    act_s       = ACT_BRANCH;
                    flush_cnt_s = FLUSH_INIT;
                    state_s     = BRANCH_TO_FLUSH ? ST_FLUSH : ST_IDLE;
                end else begin
                    act_s       = ACT_FLUSH_BUB;
                    flush_cnt_s = flush_cnt_r - 3'd1;
                    state_s     = (flush_cnt_r == 3'd1) ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_ERR: begin
                act_s   = ACT_FREEZE;
                state_s = ST_ERR;
            end
            default: begin
                act_s   = ACT_FREEZE;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Decode the chosen action into pipeline-register controls
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_we     = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        mem_err     = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (act_s)
                ACT_ADVANCE: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                end
                ACT_FREEZE: begin
                    exmem_hold = 1'b1;
                end
                ACT_BRANCH: begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_we     = 1'b1;
                    idex_bubble = 1'b1;
                end
                ACT_LOAD_USE: begin
                    idex_we     = 1'b1;
                    idex_bubble = 1'b1;
                end
                ACT_FLUSH_BUB: begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    idex_we     = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: begin
                    exmem_hold = 1'b1;
                end
            endcase
            mem_err = (state_r == ST_ERR);
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            timer_r      <= 10'd0;
            pend_flush_r <= 1'b0;
            flush_cnt_r  <= 3'd0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            pend_flush_r <= pend_flush_s;
            flush_cnt_r  <= flush_cnt_s;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating stall-cycle and flush-event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= {CNT_W{1'b0}};
            flush_events <= {CNT_W{1'b0}};
        end else begin
            if (!pc_we && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (ifid_flush && (flush_events != CNT_MAX)) begin
                flush_events <= flush_events + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic, checked each cycle
// against a behavioural model of the pipeline-control rules.
module tb_pipe_hazard_ctrl;
    localparam int FC = 2;
    localparam int MT = 8;
    localparam int CW = 4;

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_hold, mem_err}
    localparam logic [6:0] O_ADV = 7'b1101000;
    localparam logic [6:0] O_FRZ = 7'b0000010;
    localparam logic [6:0] O_BR  = 7'b1111100;
    localparam logic [6:0] O_LU  = 7'b0001100;
    localparam logic [6:0] O_FB  = 7'b1101100;
    localparam logic [6:0] O_ERR = 7'b0000011;
    localparam logic [6:0] O_RST = 7'b0010100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs_id = 5'd0;
    logic [4:0] rt_id = 5'd0;
    logic [4:0] rt_ex = 5'd0;
    logic       memread_ex = 1'b0;
    logic       branch_taken_ex = 1'b0;
    logic       dmem_req = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_hold, mem_err;
    logic [1:0] state_o;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0] stall_cycles, flush_events;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs_id(rs_id), .rt_id(rt_id), .rt_ex(rt_ex),
        .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_hold(exmem_hold),
        .mem_err(mem_err),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
        .state_o(state_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: waiting on memory, sticky error, branch pending, frozen cycles so far, bubbles still owed
    bit m_wait = 1'b0;
    bit m_err = 1'b0;
    bit m_pend = 1'b0;
    int m_waited = 0;
    int m_bub = 0;
    int m_stall = 0;
    int m_flushev = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rs_id = 5'd0; rt_id = 5'd0; rt_ex = 5'd0;
        memread_ex = 1'b0; branch_taken_ex = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
        #1;
        check("rst_ctrl", {1'b0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_hold, mem_err}, {1'b0, O_RST});
        check("rst_state", {6'd0, state_o}, 8'd0);
`ifdef HAZ_PERF_CNT_EN
        check("rst_stall_cnt", {4'd0, stall_cycles}, 8'd0);
`endif
        m_wait = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_waited = 0; m_bub = 0;
        m_stall = 0; m_flushev = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rte,
                         input logic mr, input logic br, input logic rq, input logic ak);
        logic [6:0] e;
        logic [1:0] est;
        bit         lu;
        @(negedge clk);
        rs_id = rs; rt_id = rt; rt_ex = rte;
        memread_ex = mr; branch_taken_ex = br; dmem_req = rq; dmem_ack = ak;
        #1;
        lu  = mr && (rte != 5'd0) && ((rte == rs) || (rte == rt));
        est = m_err ? 2'd3 : (m_wait ? 2'd1 : ((m_bub > 0) ? 2'd2 : 2'd0));
        if (m_err) begin
            e = O_ERR;
        end else if (m_wait) begin
            if (ak) begin
                m_wait = 1'b0;
                if (m_pend) begin
                    e = O_BR; m_pend = 1'b0; m_bub = FC - 1;
                end else begin
                    e = O_ADV;
                end
            end else begin
                e = O_FRZ;
                m_waited++;
                m_pend = m_pend | br;
                if (m_waited == MT) begin
                    m_err = 1'b1; m_wait = 1'b0;
                end
            end
        end else if (m_bub > 0) begin
            if (rq && !ak) begin
                e = O_FRZ; m_wait = 1'b1; m_waited = 1; m_pend = 1'b0; m_bub = 0;
            end else if (br) begin
                e = O_BR; m_bub = FC - 1;
            end else begin
                e = O_FB; m_bub--;
            end
        end else begin
            if (rq && !ak) begin
                e = O_FRZ; m_wait = 1'b1; m_waited = 1; m_pend = br;
            end else if (br) begin
                e = O_BR; m_bub = FC - 1;
            end else if (lu) begin
                e = O_LU;
            end else begin
                e = O_ADV;
            end
        end
        check("ctrl", {1'b0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_hold, mem_err}, {1'b0, e});
        check("state", {6'd0, state_o}, {6'd0, est});
`ifdef HAZ_PERF_CNT_EN
        check("stall_cnt", {4'd0, stall_cycles}, 8'(m_stall));
        check("flush_cnt", {4'd0, flush_events}, 8'(m_flushev));
        if (!e[6] && m_stall < (1 << CW) - 1) m_stall++;
        if (e[4] && m_flushev < (1 << CW) - 1) m_flushev++;
`endif
    endtask

    initial begin
        do_reset();
        // Load-use on rs, on rt, and the rt_ex==0 exemption
        apply(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(5'd1, 5'd2, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(5'd4, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        // Taken branch: flush then bubble sequence
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Memory wait of 5 frozen cycles then ack
        repeat (5) apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Branch arriving mid-wait is deferred to the ack cycle
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Timeout after MT frozen cycles, sticky until reset
        repeat (MT) apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        // Ack on the timeout cycle wins
        repeat (MT - 1) apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Branch outranks load-use; branch restarts flush; mem stall out of flush
        apply(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Asynchronous reset mid-wait and mid-flush
        repeat (3) apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_reset();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Random traffic with small register indices so hazards collide often
        for (int i = 0; i < 800; i++) begin
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end
            apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
